// File: rtl/nn_cfg_sequencer.sv
// nn_cfg_sequencer: walks every layer/neuron of nn_top, reads weight and
// bias words from a read-only source memory and replays them as AXI4-Lite
// register writes (0 = weight, 4 = bias, 12 = layer, 16 = neuron).
// One write is outstanding at a time; done pulses at the end of each pass.
module nn_cfg_sequencer #(
  parameter int unsigned NUM_LAYERS  = 3,
  parameter int unsigned NUM_NEURONS = 30,
  parameter int unsigned NUM_WEIGHTS = 784,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MEM_AW      = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready
);

  localparam int unsigned LAYER_W  = $clog2(NUM_LAYERS + 1);
  localparam int unsigned NEURON_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned T_W      = $clog2(NUM_WEIGHTS + 1);

  localparam logic [LAYER_W-1:0]  LAYER_FIRST = LAYER_W'(1);
  localparam logic [LAYER_W-1:0]  LAYER_LAST  = LAYER_W'(NUM_LAYERS);
  localparam logic [NEURON_W-1:0] NEURON_LAST = NEURON_W'(NUM_NEURONS - 1);
  localparam logic [T_W-1:0]      T_BIAS      = T_W'(NUM_WEIGHTS);

  localparam logic [31:0] REG_WEIGHT = 32'd0;
  localparam logic [31:0] REG_BIAS   = 32'd4;
  localparam logic [31:0] REG_LAYER  = 32'd12;
  localparam logic [31:0] REG_NEURON = 32'd16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_FETCH,
    S_WAIT_MEM,
    S_WR,
    S_RESP,
    S_DONE
  } state_e;

  // Kind of the write currently being produced.
  typedef enum logic [1:0] {
    K_LAYER,
    K_NEURON,
    K_DATA
  } item_e;

  state_e                state_q, state_d;
  item_e                 item_q, item_d;
  logic [LAYER_W-1:0]    layer_q, layer_d;
  logic [NEURON_W-1:0]   neuron_q, neuron_d;
  logic [T_W-1:0]        t_q, t_d;
  logic [MEM_AW-1:0]     addr_q, addr_d;
  logic [31:0]           awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  error_q, error_d;
  logic                  last_item;

  // The bias of the last neuron of the last layer closes the pass.
  assign last_item = (item_q == K_DATA) && (t_q == T_BIAS) &&
                     (neuron_q == NEURON_LAST) && (layer_q == LAYER_LAST);

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign error         = error_q;
  assign mem_rd_en     = (state_q == S_FETCH);
  assign mem_addr      = addr_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == S_RESP);

  // Sequencer state, walk counters and AXI channel registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      item_q    <= K_LAYER;
      layer_q   <= LAYER_FIRST;
      neuron_q  <= '0;
      t_q       <= '0;
      addr_q    <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      item_q    <= item_d;
      layer_q   <= layer_d;
      neuron_q  <= neuron_d;
      t_q       <= t_d;
      addr_q    <= addr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      error_q   <= error_d;
    end
  end

  // Next-state, counter advance and write-channel control.
  always_comb begin
    state_d   = state_q;
    item_d    = item_q;
    layer_d   = layer_q;
    neuron_d  = neuron_q;
    t_d       = t_q;
    addr_d    = addr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    error_d   = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SEL;
          item_d   = K_LAYER;
          layer_d  = LAYER_FIRST;
          neuron_d = '0;
          t_d      = '0;
          addr_d   = '0;
          error_d  = 1'b0;
        end
      end

      S_SEL: begin
        if (item_q == K_DATA) begin
          state_d = S_FETCH;
        end else begin
          awaddr_d  = (item_q == K_LAYER) ? REG_LAYER : REG_NEURON;
          wdata_d   = (item_q == K_LAYER) ? 32'(layer_q) : 32'(neuron_q);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_WR;
        end
      end

      S_FETCH: begin
        state_d = S_WAIT_MEM;
      end

      S_WAIT_MEM: begin
        awaddr_d  = (t_q == T_BIAS) ? REG_BIAS : REG_WEIGHT;
        wdata_d   = 32'(mem_rdata);
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        state_d   = S_WR;
      end

      // A valid that is already low has completed its handshake, so no
      // separate per-channel done flags are needed.
      S_WR: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = S_RESP;
      end

      S_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else if (last_item) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SEL;
            unique case (item_q)
              K_LAYER:  item_d = K_NEURON;
              K_NEURON: item_d = K_DATA;
              default: begin
                // Memory words are laid out in exactly the walk order.
                addr_d = addr_q + MEM_AW'(1);
                if (t_q == T_BIAS) begin
                  t_d = '0;
                  if (neuron_q == NEURON_LAST) begin
                    neuron_d = '0;
                    layer_d  = layer_q + LAYER_W'(1);
                    item_d   = K_LAYER;
                  end else begin
                    neuron_d = neuron_q + NEURON_W'(1);
                    item_d   = K_NEURON;
                  end
                end else begin
                  t_d = t_q + T_W'(1);
                end
              end
            endcase
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
